// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT butterfly sequencer.
package fft_pkg;

  localparam int unsigned FFT_N     = 8;
  localparam int unsigned FFT_LOG2N = 3;
  localparam int unsigned TW_W      = FFT_LOG2N - 1;
  localparam int unsigned STAGE_W   = 2;
  localparam int unsigned BR_MAXW   = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    GAP   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } sched_state_e;

  // Reverse the low w bits of x; bits at and above w come back as zero.
  function automatic logic [BR_MAXW-1:0] bitrev(input logic [BR_MAXW-1:0] x,
                                                input int unsigned        w);
    logic [BR_MAXW-1:0] r;
    logic [BR_MAXW-1:0] xs;
    r  = '0;
    xs = x;
    for (int unsigned i = 0; i < BR_MAXW; i++) begin
      if (i < w) begin
        r  = {r[BR_MAXW-2:0], xs[0]};
        xs = xs >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address generator: (stage s, butterfly j) -> leg addresses a/b and twiddle exponent.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = FFT_LOG2N,
  parameter int unsigned TWW   = TW_W
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [LOG2N-2:0]   j,
  output logic [LOG2N-1:0]   a,
  output logic [LOG2N-1:0]   b,
  output logic [TWW-1:0]     tw
);

  logic [LOG2N-1:0] jw;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] k;
  logic [LOG2N-1:0] g;

  // k = j mod 2^s, g = j >> s; a = g*2^(s+1) + k; b = a + 2^s; tw = k * N/2^(s+1)
  always_comb begin
    jw   = LOG2N'(j);
    span = LOG2N'(1) << stage;
    k    = jw & (span - LOG2N'(1));
    g    = jw >> stage;
    a    = ((g << stage) << 1) | k;
    b    = a | span;
    tw   = TWW'(k << (LOG2N - 1 - 32'(stage)));
  end

endmodule

// File: rtl/fft8_bfu_sched.sv
// Load/butterfly/write-back sequencer for an in-place radix-2 DIT FFT core.
// Define FFT_SCHED_BITREV_EN to bit-reverse load addresses (natural-order input).
module fft8_bfu_sched
  import fft_pkg::*;
#(
  parameter int unsigned N      = FFT_N,
  parameter int unsigned LOG2N  = FFT_LOG2N,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               ld_we,
  output logic [LOG2N-1:0]   ld_addr,
  output logic               rd_en,
  output logic [LOG2N-1:0]   rd_addr_a,
  output logic [LOG2N-1:0]   rd_addr_b,
  output logic [LOG2N-2:0]   sel_w,
  output logic               wr_en,
  output logic [LOG2N-1:0]   wr_addr_a,
  output logic [LOG2N-1:0]   wr_addr_b,
  output logic [STAGE_W-1:0] stage,
  output logic               busy,
  output logic               done
);

  localparam int unsigned JW    = LOG2N - 1;
  localparam int unsigned LAT_W = 2;
  localparam int unsigned OPW   = 1 + 2 * LOG2N + JW;
  localparam int unsigned PW    = RD_LAT * OPW;

  sched_state_e       state_q;
  sched_state_e       state_d;
  logic [LOG2N-1:0]   ld_cnt_q;
  logic [LOG2N-1:0]   ld_cnt_d;
  logic [LOG2N-1:0]   ld_addr_d;
  logic [JW-1:0]      bf_cnt_q;
  logic [JW-1:0]      bf_cnt_d;
  logic [STAGE_W-1:0] s_q;
  logic [STAGE_W-1:0] s_d;
  logic [LAT_W-1:0]   lat_q;
  logic [LAT_W-1:0]   lat_d;
  logic [LOG2N-1:0]   ag_a;
  logic [LOG2N-1:0]   ag_b;
  logic [JW-1:0]      ag_tw;
  logic [JW-1:0]      tw_q;
  logic [PW-1:0]      pipe_q;
  logic               calc_d;
  logic               load_d;

  // Addresses are computed for the next cycle's butterfly so rd_addr_* come straight from flops.
  fft_addr_gen #(
    .LOG2N (LOG2N),
    .TWW   (JW)
  ) u_addr_gen (
    .stage (s_d),
    .j     (bf_cnt_d),
    .a     (ag_a),
    .b     (ag_b),
    .tw    (ag_tw)
  );

`ifdef FFT_SCHED_BITREV_EN
  assign ld_addr_d = LOG2N'(bitrev(BR_MAXW'(ld_cnt_d), LOG2N));
`else
  assign ld_addr_d = ld_cnt_d;
`endif

  // Next-state and counter update.
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    bf_cnt_d = bf_cnt_q;
    s_d      = s_q;
    lat_d    = lat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (ld_cnt_q == LOG2N'(N - 1)) begin
            ld_cnt_d = '0;
            state_d  = CALC;
          end else begin
            ld_cnt_d = ld_cnt_q + LOG2N'(1);
          end
        end
      end
      CALC: begin
        if (bf_cnt_q == JW'(N / 2 - 1)) begin
          bf_cnt_d = '0;
          lat_d    = '0;
          state_d  = (s_q == STAGE_W'(LOG2N - 1)) ? DRAIN : GAP;
        end else begin
          bf_cnt_d = bf_cnt_q + JW'(1);
        end
      end
      GAP: begin
        // Hold off the next stage until the last write-back of this one has landed.
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          lat_d   = '0;
          s_d     = s_q + STAGE_W'(1);
          state_d = CALC;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      DRAIN: begin
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          lat_d   = '0;
          s_d     = '0;
          state_d = DONE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign calc_d = (state_d == CALC);
  assign load_d = (state_d == LOAD);

  // State, counters, registered outputs and the read-to-write delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ld_cnt_q  <= '0;
      bf_cnt_q  <= '0;
      s_q       <= '0;
      lat_q     <= '0;
      in_ready  <= 1'b0;
      ld_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_q      <= '0;
      stage     <= '0;
      pipe_q    <= '0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      bf_cnt_q  <= bf_cnt_d;
      s_q       <= s_d;
      lat_q     <= lat_d;
      in_ready  <= load_d;
      ld_addr   <= load_d ? ld_addr_d : '0;
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
      rd_en     <= calc_d;
      rd_addr_a <= calc_d ? ag_a : '0;
      rd_addr_b <= calc_d ? ag_b : '0;
      tw_q      <= calc_d ? ag_tw : '0;
      stage     <= s_d;
      pipe_q    <= (pipe_q << OPW) | PW'({rd_en, rd_addr_a, rd_addr_b, tw_q});
    end
  end

  assign ld_we = in_valid & in_ready;
  assign {wr_en, wr_addr_a, wr_addr_b, sel_w} = pipe_q[PW-1 -: OPW];

endmodule

// File: tb/tb_fft8_bfu_sched.sv
// Directed bench: runs an RD_LAT=1 and an RD_LAT=3 sequencer side by side against hand tables.
`timescale 1ns/1ps
module tb_fft8_bfu_sched;

  localparam int NB      = 12;
  localparam int K_LD    = 0;
  localparam int K_RD    = 1;
  localparam int K_WR    = 2;
  localparam int K_DONE  = 3;
  localparam int K_AFTER = 4;

  typedef struct {
    int d;
    int kind;
    int cyc;
    int v;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            start;
  logic            in_valid;
  logic [1:0]      in_ready, ld_we, rd_en, wr_en, busy, done;
  logic [1:0][2:0] ld_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0][1:0] sel_w, stage;

  int   lat_of[2] = '{1, 3};
  int   exp_a[NB] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int   exp_b[NB] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int   exp_w[NB] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
`ifdef FFT_SCHED_BITREV_EN
  int   exp_ld[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
  int   exp_ld[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic [1:0] prev_done = 2'b00;
  ev_t  evq[$];

  fft8_bfu_sched #(.N(8), .LOG2N(3), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready[0]), .ld_we(ld_we[0]), .ld_addr(ld_addr[0]),
    .rd_en(rd_en[0]), .rd_addr_a(rd_addr_a[0]), .rd_addr_b(rd_addr_b[0]),
    .sel_w(sel_w[0]), .wr_en(wr_en[0]), .wr_addr_a(wr_addr_a[0]),
    .wr_addr_b(wr_addr_b[0]), .stage(stage[0]), .busy(busy[0]), .done(done[0])
  );

  fft8_bfu_sched #(.N(8), .LOG2N(3), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready[1]), .ld_we(ld_we[1]), .ld_addr(ld_addr[1]),
    .rd_en(rd_en[1]), .rd_addr_a(rd_addr_a[1]), .rd_addr_b(rd_addr_b[1]),
    .sel_w(sel_w[1]), .wr_en(wr_en[1]), .wr_addr_a(wr_addr_a[1]),
    .wr_addr_b(wr_addr_b[1]), .stage(stage[1]), .busy(busy[1]), .done(done[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge, one entry per strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (ld_we[d]) evq.push_back('{d, K_LD, cyc, int'(ld_addr[d])});
        if (rd_en[d]) evq.push_back('{d, K_RD, cyc, int'(rd_addr_a[d]) * 256 + int'(rd_addr_b[d]) * 16 + int'(stage[d])});
        if (wr_en[d]) evq.push_back('{d, K_WR, cyc, int'(wr_addr_a[d]) * 256 + int'(wr_addr_b[d]) * 16 + int'(sel_w[d])});
        if (done[d]) evq.push_back('{d, K_DONE, cyc, 1});
        if (prev_done[d]) evq.push_back('{d, K_AFTER, cyc, int'(busy[d])});
      end
    end
    prev_done <= done;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs(input int d);
    return int'({in_ready[d], ld_we[d], ld_addr[d], rd_en[d], rd_addr_a[d], rd_addr_b[d],
                 sel_w[d], wr_en[d], wr_addr_a[d], wr_addr_b[d], stage[d], busy[d], done[d]});
  endfunction

  task automatic eval_run(input int d, input string run);
    int lat;
    int n_ld, n_rd, n_wr, n_dn, t0, t_ld;
    lat = lat_of[d];
    n_ld = 0; n_rd = 0; n_wr = 0; n_dn = 0; t0 = 0; t_ld = 0;
    foreach (evq[i]) begin
      if (evq[i].d != d) continue;
      case (evq[i].kind)
        K_LD: begin
          if (n_ld < 8) chk($sformatf("%s L%0d ld_addr%0d", run, lat, n_ld), evq[i].v, exp_ld[n_ld]);
          n_ld++;
          t_ld = evq[i].cyc;
        end
        K_RD: begin
          if (n_rd == 0) t0 = evq[i].cyc;
          if (n_rd < NB) begin
            chk($sformatf("%s L%0d rd%0d a/b/stage", run, lat, n_rd), evq[i].v,
                exp_a[n_rd] * 256 + exp_b[n_rd] * 16 + n_rd / 4);
            chk($sformatf("%s L%0d rd%0d cycle", run, lat, n_rd), evq[i].cyc - t0,
                n_rd + (n_rd / 4) * lat);
          end
          n_rd++;
        end
        K_WR: begin
          if (n_wr < NB) begin
            chk($sformatf("%s L%0d wr%0d a/b/sel_w", run, lat, n_wr), evq[i].v,
                exp_a[n_wr] * 256 + exp_b[n_wr] * 16 + exp_w[n_wr]);
            chk($sformatf("%s L%0d wr%0d cycle", run, lat, n_wr), evq[i].cyc - t0,
                n_wr + (n_wr / 4) * lat + lat);
          end
          n_wr++;
        end
        K_DONE: begin
          n_dn++;
          chk($sformatf("%s L%0d done cycle", run, lat), evq[i].cyc - t0, NB + 3 * lat);
        end
        default: begin
          chk($sformatf("%s L%0d busy after done", run, lat), evq[i].v, 0);
        end
      endcase
    end
    chk($sformatf("%s L%0d ld_we count", run, lat), n_ld, 8);
    chk($sformatf("%s L%0d rd_en count", run, lat), n_rd, NB);
    chk($sformatf("%s L%0d wr_en count", run, lat), n_wr, NB);
    chk($sformatf("%s L%0d done count", run, lat), n_dn, 1);
    chk($sformatf("%s L%0d load to calc", run, lat), t0 - t_ld, 1);
  endtask

  // Full transform; toggle=1 feeds in_valid as 1,0,1,0...; start pulsed and in_valid held during CALC.
  task automatic do_run(input bit toggle, input string run);
    int  acc;
    bit  seen0, seen1;
    acc = 0; seen0 = 1'b0; seen1 = 1'b0;
    evq.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && acc < 8; i++) begin
      in_valid = toggle ? (i % 2 == 0) : 1'b1;
      @(negedge clk);
      if (i == 0) begin
        chk({run, " in_ready in LOAD"}, int'(in_ready[0]), 1);
        chk({run, " busy in LOAD"}, int'(busy[1]), 1);
      end
      if (ld_we[0]) acc++;
      tick();
    end
    chk({run, " samples accepted"}, acc, 8);
    in_valid = 1'b1;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 80 && !(seen0 && seen1); i++) begin
      @(negedge clk);
      if (done[0]) seen0 = 1'b1;
      if (done[1]) seen1 = 1'b1;
    end
    chk({run, " both done seen"}, int'(seen0 && seen1), 1);
    tick();
    tick();
    in_valid = 1'b0;
    eval_run(0, run);
    eval_run(1, run);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outs L1", outs(0), 0);
    chk("reset outs L3", outs(1), 0);
    tick();
    rst_n = 1'b1;

    // in_valid while idle must not produce load strobes
    mon_en = 1'b1;
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    n = 0;
    foreach (evq[i]) if (evq[i].kind == K_LD) n++;
    chk("idle ld_we count", n, 0);
    chk("idle busy", int'(busy), 0);

    do_run(1'b0, "A");
    do_run(1'b1, "B");

    // Abort in stage 1 at butterfly j=2
    evq.delete();
    found = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (rd_en[0] && stage[0] == 2'd1 && rd_addr_a[0] == 3'd4) found = 1'b1;
    end
    chk("reset trigger reached", int'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("mid reset outs L1", outs(0), 0);
    chk("mid reset outs L3", outs(1), 0);
    in_valid = 1'b0;
    repeat (2) tick();
    evq.delete();
    rst_n = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("post reset strobes", evq.size(), 0);
    chk("post reset busy", int'(busy), 0);
    tick();

    do_run(1'b0, "D");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fft8_bfu_sched.md
Name: fft8_bfu_sched

Overview:
Sequencer for the radix-2 butterfly unit in an in-place N-point DIT FFT core.
- Loads N complex samples into an external dual-port sample RAM.
- Walks log2(N) stages of N/2 butterflies each.
- Drives read addresses, the twiddle select (sel_w), and delayed write-back addresses for the combinational BFU sitting between the RAM read ports and write ports.
- Contains no datapath; addresses, strobes and status only.

Parameters:
N, 8, FFT length; power of two. Default matches the 2-bit BFU twiddle select.
LOG2N, 3, log2(N); sets address width.
RD_LAT, 1, RAM read latency in cycles, 1..3.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a transform; sampled only in IDLE
in_valid  in  1  input sample present on external data bus
in_ready  out  1  high throughout LOAD
ld_we  out  1  = in_valid & in_ready
ld_addr  out  LOG2N  RAM write address for the loaded sample
rd_en  out  1  butterfly read strobe
rd_addr_a  out  LOG2N  upper butterfly leg address
rd_addr_b  out  LOG2N  lower butterfly leg address
sel_w  out  LOG2N-1  twiddle exponent k for W_N^k, aligned with the RAM data (RD_LAT after rd_en)
wr_en  out  1  BFU result write strobe
wr_addr_a  out  LOG2N  write address for X0
wr_addr_b  out  LOG2N  write address for X1
stage  out  2  current stage index
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at completion

Behaviour:
- Reset (async assert, sync deassert): FSM to IDLE; all counters and shift registers cleared; every output 0. Reset mid-transform aborts with no further strobes.
- States: IDLE -> LOAD on start. LOAD -> CALC after N accepted samples. CALC -> GAP after last butterfly of a non-final stage. GAP -> CALC after RD_LAT cycles. CALC -> DRAIN after last butterfly of the final stage. DRAIN -> DONE after RD_LAT cycles. DONE -> IDLE (done=1 for that single cycle).
- start outside IDLE is ignored. in_valid outside LOAD is ignored; ld_we stays 0.
- LOAD:
  - ld_addr = bitrev(load count) (see Optional Feature).
  - Load count increments per accepted sample and wraps to 0 on exit.
- CALC, stage s, butterfly j:
  - One butterfly issued per cycle, rd_en=1.
  - k = j mod 2^s; g = j >> s.
  - a = g*2^(s+1) + k; b = a + 2^s.
  - Twiddle exponent = k*(N >> (s+1)).
- Pipeline:
  - a, b and the twiddle exponent travel through an RD_LAT-deep shift register.
  - wr_en, wr_addr_a, wr_addr_b and sel_w appear exactly RD_LAT cycles after the matching rd_en.
  - RAM captures the writes on the following edge.
- GAP: exactly RD_LAT idle cycles; the first read of stage s+1 never precedes the last write of stage s.
- Cycle counts (DRAIN included):
  - CALC+GAP+DRAIN = log2(N)*N/2 + LOG2N*RD_LAT.
  - N=8, RD_LAT=1: 15 cycles.
- done asserts the cycle after the final wr_en, then the FSM returns to IDLE. A new start is accepted in the cycle after done.
- stage holds s during CALC and its following GAP; 0 in IDLE.

Optional Feature:
Macro FFT_SCHED_BITREV_EN.
- Defined: ld_addr = bit-reversed load count; inputs arrive in natural order.
- Undefined: ld_addr = load count; the upstream source supplies bit-reversed order.
- Butterfly sequencing is identical either way.

Decomposition:
- Package fft_pkg holds: N/LOG2N defaults, sched state enum (IDLE, LOAD, CALC, GAP, DRAIN, DONE), bitrev function, twiddle-exponent width constant.
- One sub-module, fft_addr_gen: purely combinational (stage, j) -> (a, b, twiddle exponent). It is instantiated once and unit-testable in isolation.

Test Plan:
- Reset mid-CALC (rst_n low at stage 1, j=2) -> all outputs 0 immediately; after release busy=0, no wr_en; next start runs a full transform.
- N=8, RD_LAT=1, start then 8 samples back-to-back -> stage0 (a,b,sel_w) = (0,1,0),(2,3,0),(4,5,0),(6,7,0).
  - stage1: (0,2,0),(1,3,2),(4,6,0),(5,7,2).
  - stage2: (0,4,0),(1,5,1),(2,6,2),(3,7,3).
- Same run -> wr_en trails each rd_en by exactly 1 cycle; one idle cycle between stages; done exactly 15 cycles after first CALC cycle; busy low next cycle.
- in_valid toggling 1,0,1,0 during LOAD -> exactly 8 ld_we pulses. With FFT_SCHED_BITREV_EN: ld_addr = 0,4,2,6,1,5,3,7. Without: ld_addr = 0..7.
- start pulsed during CALC, and in_valid held in IDLE -> no effect on sequence; ld_we=0.
- RD_LAT=3 -> wr_en/sel_w delayed 3 cycles; 3-cycle gaps; done 12+9=21 cycles after first CALC cycle.
